// File: rtl/timeout_pkg.sv
// Shared definitions for the timeout converter.
//   state_t       converter FSM states
//   MACRO_*       fixed-point constants for the macro (MCLK) period
//   NS_PER_US     nanoseconds per microsecond
//   MACRO_PERIOD  macro period in ns for a VCSEL period given in PCLKs
package timeout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MACRO,
        ST_PREP,
        ST_DIV,
        ST_RESULT,
        ST_ENCODE,
        ST_DONE
    } state_t;

    localparam int unsigned MACRO_MUL_A = 2304;
    localparam int unsigned MACRO_MUL_B = 1655;
    localparam int unsigned MACRO_ROUND = 500;
    localparam int unsigned MACRO_RECIP = 66;
    localparam int unsigned MACRO_SHIFT = 16;
    localparam int unsigned NS_PER_US   = 1000;

    // The intermediate product passes 2^32 at vcsel=18, so work at 64 bits.
    function automatic logic [63:0] MACRO_PERIOD(input logic [7:0] vcsel_period_pclks);
        logic [63:0] prod;
        prod = 64'(vcsel_period_pclks) * 64'(MACRO_MUL_A) * 64'(MACRO_MUL_B);
        prod = (prod + 64'(MACRO_ROUND)) * 64'(MACRO_RECIP);
        return prod >> MACRO_SHIFT;
    endfunction

endpackage

// File: rtl/timeout_converter_seq_divider.sv
// Restoring radix-2 divider, one quotient bit per cycle, DIV_W iterations.
// start loads the operands; done pulses for one cycle once the quotient and
// remainder are final, and they hold until the next start.
// A zero divisor naturally yields an all-ones quotient.
//   clk, reset (sync, active high), start
//   dividend, divisor  -> quotient, remainder, done
module seq_divider #(
    parameter int DIV_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;

    // Partial remainder stays below the divisor, so trial fits in DIV_W+1 bits
    // and the top bit of diff is the borrow.
    always_comb begin
        trial = {rem_q, quo_q[DIV_W-1]};
        diff  = trial - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dsr_q <= divisor;
                cnt_q <= CNT_W'(DIV_W);
            end else if (cnt_q != '0) begin
                if (!diff[DIV_W]) begin
                    rem_q <= diff[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], 1'b1};
                end else begin
                    rem_q <= trial[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], 1'b0};
                end
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) done <= 1'b1;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/timeout_converter.sv
// Bidirectional timeout converter: microseconds <-> macro-clock counts.
//   mode 0: timeout_us_in    -> timeout_mclks_out
//   mode 1: timeout_mclks_in -> timeout_us_out
// Ports: clk, reset (sync, active high), start, mode, vcsel_period_pclks,
//   timeout_us_in, timeout_mclks_in, busy, done, timeout_mclks_out,
//   timeout_us_out, sat, err.
// Optional build macro TIMEOUT_ENCODE_EN adds in_encoded and timeout_reg_enc
// (register-format encode/decode) and one extra cycle of latency.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start, operands latched on accept
// ST_MACRO  | macro period computed and registered
// ST_PREP   | divider loaded with mode-specific operands
// ST_DIV    | waiting for divider done
// ST_RESULT | clip quotient, set sat/err, update active output
// ST_ENCODE | register-format encode of the mclks result
// ST_DONE   | done pulse
module timeout_converter
    import timeout_pkg::*;
#(
    parameter int US_W   = 32,
    parameter int MCLK_W = 16,
    parameter int DIV_W  = 48
) (
    input  logic              clk,
    input  logic              reset,
`ifdef TIMEOUT_ENCODE_EN
    input  logic              in_encoded,
    output logic [15:0]       timeout_reg_enc,
`endif
    input  logic              start,
    input  logic              mode,
    input  logic [7:0]        vcsel_period_pclks,
    input  logic [US_W-1:0]   timeout_us_in,
    input  logic [MCLK_W-1:0] timeout_mclks_in,
    output logic              busy,
    output logic              done,
    output logic [MCLK_W-1:0] timeout_mclks_out,
    output logic [US_W-1:0]   timeout_us_out,
    output logic              sat,
    output logic              err
);

    state_t            state_q, state_d;
    logic              mode_q;
    logic [7:0]        vcsel_q;
    logic [US_W-1:0]   us_q;
    logic [MCLK_W-1:0] mclks_q;
    logic [DIV_W-1:0]  mp_q;
    logic [MCLK_W-1:0] mclks_op;

    logic              div_start, div_done;
    logic [DIV_W-1:0]  div_dividend, div_divisor, div_quotient, div_remainder;
    logic              unused_rem;

    assign unused_rem = ^div_remainder;

`ifdef TIMEOUT_ENCODE_EN
    // Register format only describes MCLK_W-bit counts; larger encodings clip.
    logic [MCLK_W+7:0] dec_wide;
    logic [MCLK_W-1:0] dec_val;
    logic [MCLK_W-1:0] enc_v;
    logic [7:0]        enc_ms;
    logic [7:0]        enc_ls;
    logic [15:0]       enc_value;

    always_comb begin
        dec_wide = (MCLK_W+8)'(timeout_mclks_in[7:0]) << timeout_mclks_in[15:8];
        if (timeout_mclks_in[15:8] >= 8'(MCLK_W) || |dec_wide[MCLK_W+7:MCLK_W])
            dec_val = '1;
        else
            dec_val = dec_wide[MCLK_W-1:0] + MCLK_W'(1);
        mclks_op = (mode && in_encoded) ? dec_val : timeout_mclks_in;
    end

    // Highest set bit above bit 7 sets the exponent so the mantissa fits 8 bits.
    always_comb begin
        enc_v  = timeout_mclks_out - MCLK_W'(1);
        enc_ms = '0;
        for (int i = 8; i < MCLK_W; i++) begin
            if (enc_v[i]) enc_ms = 8'(i - 7);
        end
        enc_ls    = 8'(enc_v >> enc_ms);
        enc_value = (timeout_mclks_out == '0) ? 16'h0000 : {enc_ms, enc_ls};
    end
`else
    assign mclks_op = timeout_mclks_in;
`endif

    always_comb begin
        if (!mode_q) begin
            div_dividend = DIV_W'(us_q) * DIV_W'(NS_PER_US) + (mp_q >> 1);
            div_divisor  = mp_q;
        end else begin
            div_dividend = DIV_W'(mclks_q) * mp_q + DIV_W'(NS_PER_US / 2);
            div_divisor  = DIV_W'(NS_PER_US);
        end
    end

    seq_divider #(.DIV_W(DIV_W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .done      (div_done)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_MACRO;
            ST_MACRO:  state_d = ST_PREP;
            ST_PREP: begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV:    if (div_done) state_d = ST_RESULT;
`ifdef TIMEOUT_ENCODE_EN
            ST_RESULT: state_d = ST_ENCODE;
            ST_ENCODE: state_d = ST_DONE;
`else
            ST_RESULT: state_d = ST_DONE;
`endif
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            mode_q            <= 1'b0;
            vcsel_q           <= '0;
            us_q              <= '0;
            mclks_q           <= '0;
            mp_q              <= '0;
            timeout_mclks_out <= '0;
            timeout_us_out    <= '0;
            sat               <= 1'b0;
            err               <= 1'b0;
`ifdef TIMEOUT_ENCODE_EN
            timeout_reg_enc   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                mode_q  <= mode;
                vcsel_q <= vcsel_period_pclks;
                us_q    <= timeout_us_in;
                mclks_q <= mclks_op;
                sat     <= 1'b0;
                err     <= 1'b0;
            end
            if (state_q == ST_MACRO) mp_q <= DIV_W'(MACRO_PERIOD(vcsel_q));
            if (state_q == ST_RESULT) begin
                if (!mode_q) begin
                    if (mp_q == '0) begin
                        err               <= 1'b1;
                        timeout_mclks_out <= '1;
                    end else if (|div_quotient[DIV_W-1:MCLK_W]) begin
                        sat               <= 1'b1;
                        timeout_mclks_out <= '1;
                    end else begin
                        timeout_mclks_out <= div_quotient[MCLK_W-1:0];
                    end
                end else begin
                    if (|div_quotient[DIV_W-1:US_W]) begin
                        sat            <= 1'b1;
                        timeout_us_out <= '1;
                    end else begin
                        timeout_us_out <= div_quotient[US_W-1:0];
                    end
                end
            end
`ifdef TIMEOUT_ENCODE_EN
            if (state_q == ST_ENCODE && !mode_q) timeout_reg_enc <= enc_value;
`endif
        end
    end

endmodule

// File: tb/tb_timeout_converter.sv
module tb_timeout_converter;

    localparam int US_W   = 32;
    localparam int MCLK_W = 16;
    localparam int DIV_W  = 48;
`ifdef TIMEOUT_ENCODE_EN
    localparam int LAT = DIV_W + 5;
`else
    localparam int LAT = DIV_W + 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  vcsel = '0;
    logic [31:0] us_in = '0;
    logic [15:0] mc_in = '0;
    logic        in_enc = 1'b0;
    logic        busy, done, sat, err;
    logic [15:0] mc_out;
    logic [31:0] us_out;
`ifdef TIMEOUT_ENCODE_EN
    logic [15:0] enc_out;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    timeout_converter #(.US_W(US_W), .MCLK_W(MCLK_W), .DIV_W(DIV_W)) dut (
        .clk                (clk),
        .reset              (reset),
`ifdef TIMEOUT_ENCODE_EN
        .in_encoded         (in_enc),
        .timeout_reg_enc    (enc_out),
`endif
        .start              (start),
        .mode               (mode),
        .vcsel_period_pclks (vcsel),
        .timeout_us_in      (us_in),
        .timeout_mclks_in   (mc_in),
        .busy               (busy),
        .done               (done),
        .timeout_mclks_out  (mc_out),
        .timeout_us_out     (us_out),
        .sat                (sat),
        .err                (err)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural reference ----------------
    function automatic longint unsigned mp_of(input longint unsigned v);
        return ((v * 2304 * 1655 + 500) * 66) >> 16;
    endfunction

    function automatic logic [15:0] enc_of(input longint unsigned x);
        longint unsigned ls, ms;
        if (x == 0) return 16'h0000;
        ls = x - 1;
        ms = 0;
        while (ls > 255) begin
            ls = ls >> 1;
            ms++;
        end
        return 16'((ms << 8) | ls);
    endfunction

    function automatic longint unsigned dec_of(input longint unsigned r);
        longint unsigned ls, ms, v;
        ls = r & 255;
        ms = r >> 8;
        if (ms >= 16) return 65535;
        v = (ls << ms) + 1;
        return (v > 65535) ? 65535 : v;
    endfunction

    bit              m_busy = 0, m_done = 0;
    int              k = 0;
    bit              l_mode, l_enc;
    longint unsigned l_v, l_us, l_mc;
    logic [15:0]     m_mc = '0;
    logic [31:0]     m_us = '0;
    logic [15:0]     m_enc = '0;
    bit              m_sat = 0, m_err = 0;

    function automatic void apply_result();
        longint unsigned mp, q, mc;
        mp = mp_of(l_v);
        if (!l_mode) begin
            if (mp == 0) begin
                m_err = 1;
                m_mc  = 16'hFFFF;
            end else begin
                q = (l_us * 1000 + mp / 2) / mp;
                if (q > 65535) begin
                    m_sat = 1;
                    m_mc  = 16'hFFFF;
                end else begin
                    m_mc = q[15:0];
                end
            end
            m_enc = enc_of(m_mc);
        end else begin
            mc = l_enc ? dec_of(l_mc) : l_mc;
            q  = (mc * mp + 500) / 1000;
            if (q > 64'hFFFF_FFFF) begin
                m_sat = 1;
                m_us  = 32'hFFFF_FFFF;
            end else begin
                m_us = q[31:0];
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; k = 0;
            m_mc = '0; m_us = '0; m_enc = '0; m_sat = 0; m_err = 0;
        end else if (m_busy) begin
            k++;
            if (k == LAT) begin
                m_done = 1;
                apply_result();
            end else if (k == LAT + 1) begin
                m_busy = 0;
                m_done = 0;
            end
        end else if (start) begin
            m_busy = 1; k = 0;
            l_mode = mode; l_v = vcsel; l_us = us_in; l_mc = mc_in;
`ifdef TIMEOUT_ENCODE_EN
            l_enc = in_enc;
`else
            l_enc = 0;
`endif
            m_sat = 0; m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy || m_done) begin
                chk("mclks_out", mc_out, m_mc);
                chk("us_out", us_out, m_us);
                chk("sat", sat, m_sat);
                chk("err", err, m_err);
`ifdef TIMEOUT_ENCODE_EN
                chk("reg_enc", enc_out, m_enc);
`endif
            end
        end
    end

    // Called #1 after a rising edge in an idle cycle; returns likewise.
    task automatic do_op(input bit md, input logic [7:0] v, input logic [31:0] u,
                         input logic [15:0] m, input bit e, input bit noise);
        int n;
        bit got;
        mode = md; vcsel = v; us_in = u; mc_in = m; in_enc = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 0;
        while (!got && n < LAT + 20) begin
            if (done) got = 1;
            else begin
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    mode  = 1'($urandom_range(0, 1));
                    vcsel = 8'($urandom);
                    us_in = $urandom;
                    mc_in = 16'($urandom);
                    in_enc = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("latency", n, LAT);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mclks", mc_out, 0);
        chk("rst_us", us_out, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        chk("model_mp14", mp_of(14), 53762);
        chk("model_mp18", mp_of(18), 69122);

        do_op(0, 14, 1000, 0, 0, 0);
        chk("m0_us1000", mc_out, 19);
        chk("m0_sat", sat, 0);
        chk("m0_err", err, 0);

        do_op(1, 14, 0, 19, 0, 0);
        chk("m1_mclks19", us_out, 1021);
        chk("m1_hold_mclks", mc_out, 19);

        do_op(1, 18, 0, 1000, 0, 0);
        chk("m1_vcsel18", us_out, 69122);

        do_op(0, 14, 32'hFFFF_FFFF, 0, 0, 0);
        chk("sat_mclks", mc_out, 16'hFFFF);
        chk("sat_flag", sat, 1);

        do_op(0, 0, 1000, 0, 0, 0);
        chk("err_flag", err, 1);
        chk("err_mclks", mc_out, 16'hFFFF);
        chk("err_sat", sat, 0);

        do_op(0, 14, 1000, 0, 0, 1);
        chk("noise_mclks", mc_out, 19);
        chk("noise_sat", sat, 0);

        // reset while the divider is running
        mode = 0; vcsel = 14; us_in = 5000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mclks", mc_out, 0);
        chk("abort_us", us_out, 0);
        do_op(0, 14, 1000, 0, 0, 0);
        chk("after_abort", mc_out, 19);

`ifdef TIMEOUT_ENCODE_EN
        chk("enc_19", enc_out, 16'h0012);
        do_op(0, 14, 53762, 0, 0, 0);
        chk("enc_1000_mc", mc_out, 1000);
        chk("enc_1000", enc_out, 16'h02F9);
        do_op(1, 14, 0, 16'h02F9, 1, 0);
        chk("dec_02f9", us_out, 53601);
        do_op(0, 14, 0, 0, 0, 0);
        chk("enc_0", enc_out, 16'h0000);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [31:0] u;
            u = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 5000));
            do_op(1'($urandom_range(0, 1)), 8'($urandom), u, 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timeout_converter.md
Name: timeout_converter

Overview:
- Parametrised, bidirectional successor to the ranging-sensor timeout converter.
- Converts between a microsecond timeout and macro-clock (MCLK) counts for a given VCSEL period:
  - mode 0: us -> mclks
  - mode 1: mclks -> us
- Uses an internal multi-cycle sequential divider, so no divider IP core is needed.
- Sits between the sensor-configuration sequencer and the register-write engine of the sensor module.

Parameters:
- US_W, 32, width of the microsecond timeout input/output.
- MCLK_W, 16, width of the MCLK count input/output.
- DIV_W, 48, internal dividend/divisor/quotient width; must be >= US_W+10.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- mode  in  1  0: us->mclks, 1: mclks->us
- vcsel_period_pclks  in  8  VCSEL period in PCLKs
- timeout_us_in  in  US_W  operand for mode 0
- timeout_mclks_in  in  MCLK_W  operand for mode 1
- busy  out  1  high from accept until the done cycle inclusive
- done  out  1  one-cycle pulse; results valid from this cycle
- timeout_mclks_out  out  MCLK_W  mode 0 result
- timeout_us_out  out  US_W  mode 1 result
- sat  out  1  result clipped to all-ones
- err  out  1  macro period computed as 0 (divide by zero)

Behaviour:
- Reset: state IDLE; all outputs 0. Reset mid-operation aborts the conversion with no done pulse.
- Accept: start=1 in IDLE latches mode and all operands. start while busy is ignored; operand changes after accept are ignored.
- Macro period, computed at DIV_W width (no 32-bit overflow; vcsel=18 intermediate exceeds 2^32): mp = (((2304*vcsel*1655)+500)*66) >> 16.
- Mode 0:
  - dividend = us*1000 + (mp>>1); divisor = mp.
  - quotient > 2^MCLK_W-1 -> output all-ones, sat=1.
- Mode 1:
  - dividend = mclks*mp + 500; divisor = 1000.
  - quotient > 2^US_W-1 -> output all-ones, sat=1.
- mp==0 (e.g. vcsel=0) in mode 0: err=1, result all-ones, sat=0.
- FSM: IDLE -> MACRO (compute mp) -> PREP (load divider) -> DIV (wait divider done) -> RESULT (clip, flags) -> DONE (done=1) -> IDLE.
- Divider: restoring radix-2, one quotient bit per cycle, DIV_W iterations.
- Latency: done asserts exactly DIV_W+4 cycles after the accepting edge, independent of operands and mode.
- Back-to-back: start may be asserted in the cycle after done and is accepted.
- Result/flag hold: results and flags hold until the next accepted start, which clears sat/err. Only the output for the active mode updates.

Optional Feature:
- Macro: TIMEOUT_ENCODE_EN.
- Defined:
  - Adds output timeout_reg_enc [15:0].
  - Adds input in_encoded [1]; in mode 1, in_encoded=1 treats timeout_mclks_in as register format.
  - Encode (mode 0): mclks==0 -> 0. Otherwise ls=mclks-1, ms=0; while ls>255, shift ls right and increment ms; enc = {ms[7:0], ls[7:0]}.
  - Decode: (ls<<ms)+1.
  - Both done by an ENCODE state with a combinational priority encoder; adds 1 cycle (latency DIV_W+5).
- Undefined: no extra ports; latency DIV_W+4.

Decomposition:
- Package timeout_pkg:
  - state enum
  - constants MACRO_MUL_A=2304, MACRO_MUL_B=1655, MACRO_ROUND=500, MACRO_RECIP=66, MACRO_SHIFT=16, NS_PER_US=1000
  - MACRO_PERIOD function
- Sub-module seq_divider, parametrised by DIV_W:
  - ports clk, reset, start, dividend, divisor, quotient, remainder, done
  - divisor 0 -> quotient all-ones

Test Plan:
- vcsel=14, mode 0, us=1000 -> mp=53762, mclks_out=19, sat=0, err=0, done at DIV_W+4 cycles after accept.
- vcsel=14, mode 1, mclks=19 -> us_out=1021; vcsel=18 -> mp=69122, confirming 40-bit intermediate.
- vcsel=14, us=0xFFFFFFFF -> mclks_out=0xFFFF, sat=1; vcsel=0, mode 0 -> err=1, mclks_out=0xFFFF.
- start pulsed during busy and operands changed mid-operation -> ignored, single done, original result; back-to-back start after done accepted.
- reset asserted in DIV state -> no done pulse, outputs 0, next start completes normally.
- TIMEOUT_ENCODE_EN: mclks 19 -> enc 0x0012; mclks 1000 -> enc 0x02F9; decode 0x02F9 -> 997; mclks 0 -> enc 0x0000.
